midi_note_decoder: RTL and testbench



---
 rtl/midi_pkg.sv | 35 +++
 rtl/midi_note_stack.sv | 105 ++++++++++
 rtl/midi_note_decoder.sv | 122 ++++++++++++
 tb/tb_midi_note_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants and message-length helper for the note decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package midi_pkg;

  // Channel message status nibbles (upper 4 bits of a status byte)
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [7:0] SYSEX_START      = 8'hF0;
  localparam logic [7:0] SYSEX_END        = 8'hF7;
  localparam logic [7:0] REALTIME_MIN     = 8'hF8;

  // Number of data bytes that follow a channel status byte; 0 for anything
  // that is not a channel message.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status >= 8'h80 && status < SYSEX_START) begin
      case (status[7:4])
        NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: len = 2'd2;
        PROG, CH_AT:                           len = 2'd1;
        default:                               len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_note_stack.sv
// Held-note stack, newest on top; push moves a repeated note to the top, full push drops the oldest.
// Latency: one clock for push/remove/clear; top/empty/full reflect the registered stack.
// Backpressure: none, one operation accepted every cycle.
module midi_note_stack
  import midi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       remove,
  input  logic       clear,
  input  logic [6:0] note,
  output logic [6:0] top,
  output logic       empty,
  output logic       full
);

  localparam int CW = $clog2(DEPTH + 1);

  // Entry 0 is the oldest note; entry cnt_q-1 is the newest (top)
  logic [6:0]    stk_q [DEPTH];
  logic [6:0]    stk_d [DEPTH];
  logic [6:0]    cmp   [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cmp_cnt;
  logic          hit;
  int            hit_idx;

  // Locate the note, build the compacted stack without it, then apply the op
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && (CW'(i) < cnt_q) && (stk_q[i] == note)) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end

    // Entries above the hit slide down one place to close the gap
    for (int i = 0; i < DEPTH - 1; i++) begin
      cmp[i] = (hit && i >= hit_idx) ? stk_q[i+1] : stk_q[i];
    end
    cmp[DEPTH-1] = stk_q[DEPTH-1];
    cmp_cnt      = hit ? (cnt_q - 1'b1) : cnt_q;

    stk_d = stk_q;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (remove) begin
      stk_d = cmp;
      cnt_d = cmp_cnt;
    end else if (push) begin
      if (cmp_cnt == CW'(DEPTH)) begin
        // Full: shift out the oldest entry and place the note on top
        for (int i = 0; i < DEPTH - 1; i++) begin
          stk_d[i] = cmp[i+1];
        end
        stk_d[DEPTH-1] = note;
        cnt_d          = cmp_cnt;
      end else begin
        stk_d = cmp;
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == cmp_cnt) begin
            stk_d[i] = note;
          end
        end
        cnt_d = cmp_cnt + 1'b1;
      end
    end
  end

  // Stack storage and occupancy register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= stk_d[i];
      end
    end
  end

  // Select the newest entry as the top of stack
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == cnt_q) begin
        top = stk_q[i];
      end
    end
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser driving a monophonic last-note-priority gate/note interface.
// Latency: outputs update one clock after the rx_valid cycle carrying the final data byte.
// Backpressure: none, a byte may arrive every cycle and every message completes in one cycle.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit OMNI  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic [3:0] midi_channel,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [7:0] velocity,
  output logic       note_on_pulse,
  output logic       stray_data
);

  // Parser state
  logic [7:0] rs_q;         // running status byte
  logic       rs_vld_q;     // running status is a live channel status
  logic       data_cnt_q;   // first data byte of a two-byte message is stored
  logic [6:0] d1_q;         // stored first data byte
  logic       sysex_q;      // inside SysEx/system common: data bytes dropped silently
  logic [6:0] last_note_q;  // note shown while the gate is closed

  // Decode of the current byte
  logic       data_vld;
  logic       msg_done;
  logic       exec;
  logic [3:0] kind;
  logic [6:0] d1;
  logic [6:0] d2;
  logic       do_push;
  logic       do_remove;
  logic       do_clear;

  logic [6:0] stk_top;
  logic       stk_empty;
  logic       stk_full_unused;

  // Recognise a completed channel message on our channel and decode its action
  always_comb begin
    data_vld  = rx_valid & ~rx_byte[7];
    msg_done  = data_vld & rs_vld_q & ((msg_len(rs_q) == 2'd1) | data_cnt_q);
    exec      = msg_done & (OMNI | (rs_q[3:0] == midi_channel));
    kind      = rs_q[7:4];
    d1        = (msg_len(rs_q) == 2'd1) ? rx_byte[6:0] : d1_q;
    d2        = rx_byte[6:0];
    do_push   = exec & (kind == NOTE_ON) & (d2 != 7'd0);
    do_remove = exec & ((kind == NOTE_OFF) | ((kind == NOTE_ON) & (d2 == 7'd0)));
    do_clear  = exec & (kind == CC) & (d1 == CC_ALL_NOTES_OFF);
  end

  // Byte parser, velocity capture, pulses and the held-release note
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q          <= '0;
      rs_vld_q      <= 1'b0;
      data_cnt_q    <= 1'b0;
      d1_q          <= '0;
      sysex_q       <= 1'b0;
      last_note_q   <= '0;
      velocity      <= '0;
      note_on_pulse <= 1'b0;
      stray_data    <= 1'b0;
    end else begin
      note_on_pulse <= do_push;
      stray_data    <= data_vld & ~rs_vld_q & ~sysex_q;
      // Tracks the shown note so a release or clear keeps the last pitch
      last_note_q   <= midi_data[6:0];
      if (do_push) begin
        velocity <= {1'b0, d2};
      end
      if (rx_valid) begin
        if (rx_byte[7]) begin
          if (rx_byte < SYSEX_START) begin
            rs_q       <= rx_byte;
            rs_vld_q   <= 1'b1;
            data_cnt_q <= 1'b0;
            sysex_q    <= 1'b0;
          end else if (rx_byte < REALTIME_MIN) begin
            // SysEx end closes the silent window; other system bytes open it
            rs_vld_q   <= 1'b0;
            data_cnt_q <= 1'b0;
            sysex_q    <= (rx_byte != SYSEX_END);
          end
          // Realtime bytes leave all parser state untouched
        end else if (rs_vld_q) begin
          if (msg_done) begin
            data_cnt_q <= 1'b0;
          end else begin
            data_cnt_q <= 1'b1;
            d1_q       <= rx_byte[6:0];
          end
        end
      end
    end
  end

  midi_note_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (do_push),
    .remove (do_remove),
    .clear  (do_clear),
    .note   (do_push | do_remove ? d1 : 7'd0),
    .top    (stk_top),
    .empty  (stk_empty),
    .full   (stk_full_unused)
  );

  // Gate and note come straight from registered state, no input-to-output path
  assign midi_valid = ~stk_empty;
  assign midi_data  = stk_empty ? {1'b0, last_note_q} : {1'b0, stk_top};

endmodule

// File: tb/tb_midi_note_decoder.sv
// Scoreboard bench for midi_note_decoder: expected outputs queued per driven cycle.
// Latency: expectations fall due one clock after the cycle that drove them.
// Backpressure: n/a, bytes are driven back-to-back.
module tb_midi_note_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [3:0] midi_channel;

  logic [7:0] midi_data,  om_midi_data;
  logic       midi_valid, om_midi_valid;
  logic [7:0] velocity,   om_velocity;
  logic       note_on_pulse, om_note_on_pulse;
  logic       stray_data, om_stray_data;

  midi_note_decoder #(.DEPTH(4), .OMNI(1'b0)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .midi_channel  (midi_channel),
    .midi_data     (midi_data),
    .midi_valid    (midi_valid),
    .velocity      (velocity),
    .note_on_pulse (note_on_pulse),
    .stray_data    (stray_data)
  );

  midi_note_decoder #(.DEPTH(4), .OMNI(1'b1)) u_omni (
    .clk           (clk),
    .rst           (rst),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .midi_channel  (midi_channel),
    .midi_data     (om_midi_data),
    .midi_valid    (om_midi_valid),
    .velocity      (om_velocity),
    .note_on_pulse (om_note_on_pulse),
    .stray_data    (om_stray_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         seq;
    logic [7:0] d;
    logic       v;
    logic [7:0] vel;
    logic       p;
    logic       s;
    logic       om;
    logic [7:0] od;
    logic       ov;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         seq = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] cur_d = 8'd0;
  logic       cur_v = 1'b0;
  logic [7:0] cur_vel = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One driven cycle: apply inputs and queue what the outputs must be after the edge
  task automatic step(input logic r, input logic v, input logic [7:0] b, input logic p,
                      input logic s, input logic om, input logic [7:0] od, input logic ov);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    rx_valid = v;
    rx_byte  = b;
    e.due = cyc + 1;
    e.seq = seq;
    e.d   = cur_d;
    e.v   = cur_v;
    e.vel = cur_vel;
    e.p   = p;
    e.s   = s;
    e.om  = om;
    e.od  = od;
    e.ov  = ov;
    sb.push_back(e);
    seq++;
  endtask

  task automatic put(input logic [7:0] b);
    step(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic note_b(input logic [7:0] b, input logic [7:0] d, input logic v,
                        input logic [7:0] vel, input logic p);
    cur_d = d; cur_v = v; cur_vel = vel;
    step(1'b0, 1'b1, b, p, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic stray(input logic [7:0] b);
    step(1'b0, 1'b1, b, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic put_om(input logic [7:0] b, input logic [7:0] od, input logic ov);
    step(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b1, od, ov);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic rst_cyc();
    cur_d = 8'd0; cur_v = 1'b0; cur_vel = 8'd0;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
  endtask

  // Pop and compare each expectation once its cycle has come
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_eq($sformatf("b%0d midi_data", e.seq),  {24'd0, midi_data},     {24'd0, e.d});
      check_eq($sformatf("b%0d midi_valid", e.seq), {31'd0, midi_valid},    {31'd0, e.v});
      check_eq($sformatf("b%0d velocity", e.seq),   {24'd0, velocity},      {24'd0, e.vel});
      check_eq($sformatf("b%0d pulse", e.seq),      {31'd0, note_on_pulse}, {31'd0, e.p});
      check_eq($sformatf("b%0d stray", e.seq),      {31'd0, stray_data},    {31'd0, e.s});
      if (e.om) begin
        check_eq($sformatf("b%0d omni_data", e.seq),  {24'd0, om_midi_data},  {24'd0, e.od});
        check_eq($sformatf("b%0d omni_valid", e.seq), {31'd0, om_midi_valid}, {31'd0, e.ov});
      end
    end
  end

  initial begin
    logic [7:0] ons [5];
    logic [7:0] offs [3];
    logic [7:0] tops [3];
    ons  = '{8'h3C, 8'h3E, 8'h40, 8'h41, 8'h43};
    offs = '{8'h43, 8'h41, 8'h40};
    tops = '{8'd65, 8'd64, 8'd62};

    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; midi_channel = 4'd0;
    rst_cyc(); rst_cyc();
    idle();

    // Basic Note On, pulse lasts exactly one cycle
    put(8'h90); put(8'h48); note_b(8'h64, 8'd72, 1'b1, 8'd100, 1'b1);
    idle();

    // Running status, legato fall-back, final release keeps pitch
    put(8'h4A); note_b(8'h50, 8'd74, 1'b1, 8'd80, 1'b1);
    put(8'h4A); note_b(8'h00, 8'd72, 1'b1, 8'd80, 1'b0);
    put(8'h80); put(8'h48); note_b(8'h00, 8'd72, 1'b0, 8'd80, 1'b0);
    idle();

    // Realtime interleave, then SysEx silence and stray data after it
    rst_cyc();
    put(8'h90); put(8'hF8); put(8'h48); put(8'hFE);
    note_b(8'h64, 8'd72, 1'b1, 8'd100, 1'b1);
    put(8'hF0); put(8'h43); put(8'h12); put(8'hF7);
    stray(8'h3C); stray(8'h40);
    idle();

    // Channel filter versus OMNI
    rst_cyc();
    put_om(8'h91, 8'd0, 1'b0); put_om(8'h48, 8'd0, 1'b0); put_om(8'h64, 8'd72, 1'b1);
    idle();

    // Stack overflow drops the oldest note
    rst_cyc();
    put(8'h90);
    for (int i = 0; i < 5; i++) begin
      put(ons[i]);
      note_b(8'h40, ons[i], 1'b1, 8'd64, 1'b1);
    end
    put(8'h80);
    for (int i = 0; i < 3; i++) begin
      put(offs[i]);
      note_b(8'h00, tops[i], 1'b1, 8'd64, 1'b0);
    end
    put(8'h3E); note_b(8'h00, 8'd62, 1'b0, 8'd64, 1'b0);
    put(8'h3C); note_b(8'h00, 8'd62, 1'b0, 8'd64, 1'b0);
    idle();

    // All Notes Off, then reset in the middle of a message
    put(8'h90); put(8'h48); note_b(8'h64, 8'd72, 1'b1, 8'd100, 1'b1);
    put(8'h4A); note_b(8'h64, 8'd74, 1'b1, 8'd100, 1'b1);
    put(8'hB0); put(8'h7B); note_b(8'h00, 8'd74, 1'b0, 8'd100, 1'b0);
    put(8'h90); put(8'h48);
    rst_cyc();
    stray(8'h64);
    idle(); idle();

    repeat (4) @(posedge clk);
    #2;
    check_eq("drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
